// File: rtl/tpu_fetch_pkg.sv
// tpu_fetch_pkg: shared widths, fetch FSM states and FIFO entry layout for the instruction prefetch stage
package tpu_fetch_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    typedef enum logic {FS_IDLE, FS_REQ} fetch_state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular buffer with wrap-bit pointers, registered head read and synchronous clear
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, rd_nxt;
    logic do_pop;
    assign count = wr_ptr - rd_ptr;
    assign do_pop = pop && (count != '0);
    assign rd_nxt = rd_ptr + (AW+1)'(do_pop);
    // storage write; slots are only observed through valid pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end
    // pointers plus a registered copy of the next head, bypassing a word written into the head slot
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_nxt;
            rdata <= (push && wr_ptr[AW-1:0] == rd_nxt[AW-1:0]) ? wdata : mem[rd_nxt[AW-1:0]];
        end
    end
    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !clr && count[AW]));
endmodule

// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: sequential ROM prefetch into a small FIFO with flush/jump redirect
module inst_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic                   i_SCLK,
    input  logic                   i_RESET,
    input  logic                   i_REB,
    output logic                   o_RD_RQST,
    output logic [ADDR_W-1:0]      o_ADDR,
    input  logic                   i_ROM_READY,
    input  logic [DATA_W-1:0]      i_ROM_DO,
    input  logic                   i_POP,
    output logic [DATA_W-1:0]      o_INST,
    output logic [ADDR_W-1:0]      o_INST_PC,
    output logic                   o_INST_VALID,
    input  logic                   i_FLUSH,
    input  logic [ADDR_W-1:0]      i_JUMP_ADDR,
    output logic [$clog2(DEPTH):0] o_COUNT
);
    import tpu_fetch_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_t state;
    logic [ADDR_W-1:0] fetch_addr;
    logic drop;
    logic push;
    logic [ADDR_W+DATA_W-1:0] head;
    assign push = (state == FS_REQ) && i_ROM_READY && !drop && !i_FLUSH;
    assign o_INST_PC = head[ADDR_W+DATA_W-1:DATA_W];
    assign o_INST = head[DATA_W-1:0];
    assign o_INST_VALID = o_COUNT != '0;
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W+DATA_W)) u_fifo (
        .clk(i_SCLK),
        .rst(i_RESET),
        .clr(i_FLUSH),
        .push(push),
        .wdata({o_ADDR, i_ROM_DO}),
        .pop(i_POP),
        .rdata(head),
        .count(o_COUNT)
    );
    // fetch FSM: one request in flight, issued only with a free slot reserved; a flush mid-request marks its word stale
    always_ff @(posedge i_SCLK) begin
        if (i_RESET) begin
            state <= FS_IDLE;
            o_RD_RQST <= 1'b0;
            o_ADDR <= '0;
            fetch_addr <= '0;
            drop <= 1'b0;
        end else if (state == FS_IDLE) begin
            if (i_FLUSH) begin
                fetch_addr <= i_JUMP_ADDR;
            end else if (!i_REB && !o_COUNT[CW-1]) begin
                state <= FS_REQ;
                o_RD_RQST <= 1'b1;
                o_ADDR <= fetch_addr;
            end
        end else begin
            if (i_FLUSH) fetch_addr <= i_JUMP_ADDR;
            else if (i_ROM_READY && !drop) fetch_addr <= fetch_addr + ADDR_W'(1);
            if (i_ROM_READY) begin
                state <= FS_IDLE;
                o_RD_RQST <= 1'b0;
                drop <= 1'b0;
            end else if (i_FLUSH) begin
                drop <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: randomized ROM responder and queue model checking the prefetch buffer
module tb_inst_fetch_buffer;
    import tpu_fetch_pkg::*;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;
    bit clk = 0;
    logic rst, reb, pop, flush;
    logic ready = 0;
    logic [DATA_W-1:0] rom_do = '0;
    logic [ADDR_W-1:0] jump;
    logic rqst, valid;
    logic [ADDR_W-1:0] addr, inst_pc;
    logic [DATA_W-1:0] inst;
    logic [CW-1:0] count;
    logic [DATA_W-1:0] rom [2**ADDR_W];
    fetch_entry_t q[$];
    fetch_entry_t e;
    logic [ADDR_W-1:0] req_log[$];
    logic [ADDR_W-1:0] pop_pc[$];
    int pop_cyc[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [ADDR_W-1:0] p_addr = '0;
    bit stale = 0;
    bit p_rqst = 0;
    int cyc = 0, rcnt = 0, lat = 2, max_count = 0;
    int checks = 0, errors = 0;

    inst_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_SCLK(clk),
        .i_RESET(rst),
        .i_REB(reb),
        .o_RD_RQST(rqst),
        .o_ADDR(addr),
        .i_ROM_READY(ready),
        .i_ROM_DO(rom_do),
        .i_POP(pop),
        .o_INST(inst),
        .o_INST_PC(inst_pc),
        .o_INST_VALID(valid),
        .i_FLUSH(flush),
        .i_JUMP_ADDR(jump),
        .o_COUNT(count)
    );

    always #5 clk = ~clk;

    // model of the edge just taken, occupancy/head checks, then the ROM responder for the coming cycle
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            exp_addr = '0;
            stale = 0;
        end else begin
            if (p_rqst) begin
                checks++;
                if (ready ? (rqst !== 1'b0) : (rqst !== 1'b1 || addr !== p_addr)) begin
                    errors++;
                    $display("FAIL req_hold: rqst=%0b addr=%0d, required rqst=%0b addr=%0d", rqst, addr, !ready, p_addr);
                end
            end
            if (flush) begin
                q.delete();
                exp_addr = jump;
                stale = p_rqst && !ready;
            end else begin
                if (pop && q.size() != 0) begin
                    pop_pc.push_back(q[0].pc);
                    pop_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
                if (p_rqst && ready) begin
                    if (!stale) begin
                        e.pc = p_addr;
                        e.inst = rom[p_addr];
                        q.push_back(e);
                    end
                    stale = 0;
                end
            end
            if (rqst === 1'b1 && !p_rqst) begin
                req_log.push_back(addr);
                checks++;
                if (addr !== exp_addr || reb !== 1'b0 || q.size() >= DEPTH) begin
                    errors++;
                    $display("FAIL req_issue: addr=%0d reb=%0b entries=%0d, required addr=%0d reb=0 entries<%0d", addr, reb, q.size(), exp_addr, DEPTH);
                end
                exp_addr = exp_addr + 1'b1;
            end
        end
        checks++;
        if (valid !== (q.size() != 0) || count !== CW'(q.size())) begin
            errors++;
            $display("FAIL occupancy: valid=%0b count=%0d, required valid=%0b count=%0d", valid, count, q.size() != 0, q.size());
        end
        if (q.size() != 0) begin
            checks++;
            if (inst !== q[0].inst || inst_pc !== q[0].pc) begin
                errors++;
                $display("FAIL head: inst=%h pc=%0d, required inst=%h pc=%0d", inst, inst_pc, q[0].inst, q[0].pc);
            end
        end
        if (q.size() > max_count) max_count = q.size();
        p_rqst = (rqst === 1'b1);
        p_addr = addr;
        if (rqst !== 1'b1) begin
            rcnt = 0;
            ready = 0;
        end else begin
            rcnt++;
            ready = (rcnt >= lat);
        end
        rom_do = ready ? rom[addr] : DATA_W'($urandom);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_cyc.delete();
        max_count = 0;
    endtask

    task automatic apply_reset();
        rst = 1;
        repeat (2) step();
        clear_logs();
        rst = 0;
    endtask

    task automatic test_reset();
        lat = 2; reb = 0; pop = 0; flush = 0; jump = '0;
        rst = 1;
        repeat (3) step();
        checks++;
        if ({rqst, addr, valid, count, inst, inst_pc} !== '0) begin
            errors++;
            $display("FAIL reset_values: rqst=%0b addr=%0d valid=%0b count=%0d inst=%h pc=%0d, required all zero", rqst, addr, valid, count, inst, inst_pc);
        end
        clear_logs();
        rst = 0;
        step();
        checks++;
        if (rqst !== 1'b1 || addr !== '0) begin
            errors++;
            $display("FAIL first_request: rqst=%0b addr=%0d, required rqst=1 addr=0", rqst, addr);
        end
    endtask

    task automatic test_fill();
        lat = 2; reb = 0; pop = 0;
        apply_reset();
        repeat (40) step();
        checks++;
        if (req_log.size() != 4) begin
            errors++;
            $display("FAIL fill_request_count: got %0d, required 4", req_log.size());
        end
        for (int i = 0; i < req_log.size() && i < 4; i++) begin
            checks++;
            if (req_log[i] !== ADDR_W'(i)) begin
                errors++;
                $display("FAIL fill_request_addr[%0d]: got %0d, required %0d", i, req_log[i], i);
            end
        end
        checks++;
        if (count !== CW'(4) || rqst !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d rqst=%0b, required count=4 rqst=0", count, rqst);
        end
        checks++;
        if (inst_pc !== '0 || inst !== rom[0]) begin
            errors++;
            $display("FAIL fill_head: pc=%0d inst=%h, required pc=0 inst=%h", inst_pc, inst, rom[0]);
        end
    endtask

    task automatic test_stream();
        lat = 2; reb = 0; pop = 1;
        apply_reset();
        for (int i = 0; i < 300 && pop_pc.size() < 10; i++) step();
        checks++;
        if (pop_pc.size() < 10) begin
            errors++;
            $display("FAIL stream_timeout: got %0d words, required 10", pop_pc.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (pop_pc[i] !== ADDR_W'(i)) begin
                    errors++;
                    $display("FAIL stream_order[%0d]: pc=%0d, required %0d", i, pop_pc[i], i);
                end
            end
            for (int i = 1; i < 10; i++) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] != lat + 1) begin
                    errors++;
                    $display("FAIL stream_gap[%0d]: %0d cycles, required %0d", i, pop_cyc[i] - pop_cyc[i-1], lat + 1);
                end
            end
        end
        checks++;
        if (max_count > 1) begin
            errors++;
            $display("FAIL stream_occupancy: max %0d, required <= 1", max_count);
        end
        pop = 0;
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_w [4];
        exp_w = '{7'd126, 7'd127, 7'd0, 7'd1};
        lat = 2; reb = 1; pop = 1;
        apply_reset();
        flush = 1; jump = 7'd126;
        step();
        flush = 0; reb = 0;
        for (int i = 0; i < 200 && pop_pc.size() < 4; i++) step();
        checks++;
        if (pop_pc.size() < 4) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d words, required 4", pop_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_pc[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL wrap_pc[%0d]: pc=%0d, required %0d", i, pop_pc[i], exp_w[i]);
                end
            end
        end
        pop = 0;
    endtask

    task automatic test_flush_inflight();
        int r, k;
        lat = 3; reb = 0; pop = 1;
        apply_reset();
        for (int i = 0; i < 300 && !(rqst === 1'b1 && addr === 7'd5); i++) step();
        checks++;
        if (!(rqst === 1'b1 && addr === 7'd5)) begin
            errors++;
            $display("FAIL inflight_timeout: rqst=%0b addr=%0d, required rqst=1 addr=5", rqst, addr);
        end
        r = req_log.size();
        k = pop_pc.size();
        flush = 1; jump = 7'h40;
        step();
        flush = 0;
        checks++;
        if (rqst !== 1'b1 || addr !== 7'd5 || valid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_hold: rqst=%0b addr=%0d valid=%0b, required rqst=1 addr=5 valid=0", rqst, addr, valid);
        end
        for (int i = 0; i < 300 && pop_pc.size() <= k; i++) step();
        checks++;
        if (pop_pc.size() <= k || req_log.size() <= r) begin
            errors++;
            $display("FAIL inflight_redirect_timeout: words=%0d requests=%0d, required >%0d and >%0d", pop_pc.size(), req_log.size(), k, r);
        end else begin
            checks++;
            if (req_log[r] !== 7'h40) begin
                errors++;
                $display("FAIL inflight_next_req: addr=%0h, required 40", req_log[r]);
            end
            checks++;
            if (pop_pc[k] !== 7'h40) begin
                errors++;
                $display("FAIL inflight_first_pc: pc=%0h, required 40", pop_pc[k]);
            end
        end
        pop = 0;
    endtask

    task automatic test_flush_coincident();
        int k;
        lat = 2; reb = 0; pop = 0;
        apply_reset();
        for (int i = 0; i < 200 && !(count === CW'(2) && ready); i++) step();
        checks++;
        if (!(count === CW'(2) && ready)) begin
            errors++;
            $display("FAIL coincident_timeout: count=%0d ready=%0b, required count=2 ready=1", count, ready);
        end
        flush = 1; pop = 1; reb = 1; jump = 7'h10;
        step();
        flush = 0; pop = 0;
        checks++;
        if (count !== '0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL coincident_clear: count=%0d valid=%0b, required 0 and 0", count, valid);
        end
        repeat (8) step();
        checks++;
        if (count !== '0 || rqst !== 1'b0) begin
            errors++;
            $display("FAIL coincident_drop: count=%0d rqst=%0b, required 0 and 0", count, rqst);
        end
        k = pop_pc.size();
        reb = 0; pop = 1;
        for (int i = 0; i < 200 && pop_pc.size() <= k; i++) step();
        checks++;
        if (pop_pc.size() <= k) begin
            errors++;
            $display("FAIL coincident_restart_timeout: words=%0d, required >%0d", pop_pc.size(), k);
        end else if (pop_pc[k] !== 7'h10) begin
            errors++;
            $display("FAIL coincident_restart_pc: pc=%0h, required 10", pop_pc[k]);
        end
        pop = 0;
    endtask

    task automatic test_reset_mid_req();
        lat = 4; reb = 0; pop = 0;
        apply_reset();
        for (int i = 0; i < 200 && !(rqst === 1'b1 && addr === 7'd2); i++) step();
        checks++;
        if (!(rqst === 1'b1 && addr === 7'd2)) begin
            errors++;
            $display("FAIL midreq_timeout: rqst=%0b addr=%0d, required rqst=1 addr=2", rqst, addr);
        end
        step();
        rst = 1;
        step();
        checks++;
        if ({rqst, addr, valid, count, inst, inst_pc} !== '0) begin
            errors++;
            $display("FAIL midreq_reset_values: rqst=%0b addr=%0d valid=%0b count=%0d inst=%h pc=%0d, required all zero", rqst, addr, valid, count, inst, inst_pc);
        end
        step();
        clear_logs();
        rst = 0;
        for (int i = 0; i < 50 && req_log.size() == 0; i++) step();
        checks++;
        if (req_log.size() == 0) begin
            errors++;
            $display("FAIL midreq_restart_timeout: no request, required one at 0");
        end else if (req_log[0] !== '0) begin
            errors++;
            $display("FAIL midreq_restart_addr: addr=%0d, required 0", req_log[0]);
        end
    endtask

    task automatic test_random();
        int prate;
        lat = 1; reb = 0; pop = 0; prate = 2;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat = $urandom_range(1, 4);
                prate = $urandom_range(0, 4);
            end
            pop = ($urandom_range(0, 3) < prate);
            reb = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 24) == 0);
            jump = ADDR_W'($urandom);
            step();
        end
        flush = 0; pop = 0;
        checks++;
        if (pop_pc.size() < 50) begin
            errors++;
            $display("FAIL random_progress: %0d words delivered, required >= 50", pop_pc.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = DATA_W'($urandom);
        rst = 1; reb = 1; pop = 0; flush = 0; jump = '0;
        test_reset();
        test_fill();
        test_stream();
        test_wrap();
        test_flush_inflight();
        test_flush_coincident();
        test_reset_mid_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
